// File: rtl/exec_issue_arbiter_pkg.sv
// Shared definitions for the exec issue controller: FSM states, default
// datapath latency, instruction field positions and the in-flight tag record.
package sched_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam int unsigned LAT_DEFAULT = 2;

  localparam int unsigned OP_BIT   = 31;
  localparam int unsigned CIN_BIT  = 30;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned X_MSB    = 15;
  localparam int unsigned X_LSB    = 8;
  localparam int unsigned Y_MSB    = 7;
  localparam int unsigned Y_LSB    = 0;

  typedef struct packed {
    logic       valid;
    logic       id;
    logic [7:0] addr;
    logic       op;
  } tag_t;

  function automatic tag_t make_tag(input logic id, input logic [31:0] instr);
    tag_t t;
    t.valid = 1'b1;
    t.id    = id;
    t.addr  = instr[ADDR_MSB:ADDR_LSB];
    t.op    = instr[OP_BIT];
    return t;
  endfunction

endpackage

// File: rtl/exec_issue_arbiter_if.sv
// Requester, datapath, response and halt signals of the exec issue controller.
// slave: the controller side; master: the surrounding requesters/datapath.
interface exec_issue_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_instr;
  logic        req1_ready;
  logic        dp_valid;
  logic [31:0] dp_instr;
  logic        dp_cin;
  logic [7:0]  dp_result;
  logic        dp_cout;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_addr;
  logic [7:0]  rsp_data;
  logic        rsp_cout;
  logic        halt_req;
  logic        halted;
  logic        busy;

  modport slave (
    input  req0_valid, req0_instr, req1_valid, req1_instr,
           dp_result, dp_cout, halt_req,
    output req0_ready, req1_ready, dp_valid, dp_instr, dp_cin,
           rsp_valid, rsp_id, rsp_addr, rsp_data, rsp_cout, halted, busy
  );

  modport master (
    output req0_valid, req0_instr, req1_valid, req1_instr,
           dp_result, dp_cout, halt_req,
    input  req0_ready, req1_ready, dp_valid, dp_instr, dp_cin,
           rsp_valid, rsp_id, rsp_addr, rsp_data, rsp_cout, halted, busy
  );
endinterface

// File: rtl/exec_issue_arbiter_rr_arbiter2.sv
// Two-port arbiter producing a one-hot grant.
// Macro ISSUE_RR_EN: defined -> round-robin against last_grant;
// undefined -> fixed priority, port 0 always wins (no last_grant input).
module rr_arbiter2 (
  input  logic [1:0] req,
`ifdef ISSUE_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // Select one valid requester
  always_comb begin
    grant = '0;
`ifdef ISSUE_RR_EN
    if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else              grant = req;
`else
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
`endif
  end

endmodule

// File: rtl/exec_issue_arbiter.sv
// Issue controller for the 8-bit add/AND execute datapath: arbitrates two
// requesters, tracks in-flight ops in a LAT-deep tag pipeline, returns
// results to their owner, and provides a drain/halt sequence.
// Macro ISSUE_RR_EN: round-robin arbitration when defined, fixed priority
// (port 0 first) otherwise.
module exec_issue_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  exec_issue_arbiter_if.slave bus
);

  state_t      state, state_next;
  tag_t        tags [LAT];
  logic [1:0]  grant;
  logic        grant_ok;
  logic        issue;
  logic        issue_id;
  logic [31:0] issue_instr;
  logic        pending;
  logic        any_valid;

`ifdef ISSUE_RR_EN
  logic last_grant;

  rr_arbiter2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Remember the most recent winner; only an actual issue moves it
  always_ff @(posedge clk) begin
    if (reset)      last_grant <= 1'b1;
    else if (issue) last_grant <= issue_id;
  end
`else
  rr_arbiter2 u_arb (
    .req   ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );
`endif

  // Grant, handshake and datapath drive
  always_comb begin
    grant_ok       = (state == RUN) && !bus.halt_req && !reset;
    bus.req0_ready = grant_ok & grant[0];
    bus.req1_ready = grant_ok & grant[1];
    issue          = grant_ok & (|grant);
    issue_id       = grant[1];
    issue_instr    = issue_id ? bus.req1_instr : bus.req0_instr;
    bus.dp_valid   = issue;
    bus.dp_instr   = issue ? issue_instr : '0;
    bus.dp_cin     = issue & issue_instr[OP_BIT] & issue_instr[CIN_BIT];
  end

  // Tag pipeline: shifts every cycle, stage 0 loads on issue
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= issue ? make_tag(issue_id, issue_instr) : '0;
      for (int unsigned i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end
  end

  // Occupancy: pending ignores the last stage, which empties this cycle
  always_comb begin
    pending   = 1'b0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      any_valid = any_valid | tags[i].valid;
      if (i + 1 < LAT) pending = pending | tags[i].valid;
    end
  end

  // Retire from the last tag stage
  always_comb begin
    bus.rsp_valid = tags[LAT-1].valid & !reset;
    bus.rsp_id    = bus.rsp_valid & tags[LAT-1].id;
    bus.rsp_addr  = bus.rsp_valid ? tags[LAT-1].addr : '0;
    bus.rsp_data  = bus.rsp_valid ? bus.dp_result : '0;
    bus.rsp_cout  = bus.rsp_valid & tags[LAT-1].op & bus.dp_cout;
    bus.busy      = any_valid & !reset;
    bus.halted    = (state == HALTED) & !reset;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state. Emptiness is judged on the stages that survive this cycle's
  // shift, so HALTED is reached the cycle after the last retire, and straight
  // from RUN when nothing is in flight beyond the retiring stage.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (bus.halt_req) state_next = pending ? DRAIN : HALTED;
      DRAIN:   if (!pending)     state_next = bus.halt_req ? HALTED : RUN;
      HALTED:  if (!bus.halt_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Self-checking bench for exec_issue_arbiter with a behavioural datapath
// model (AND ops deliberately report carry-out 1) and a response scoreboard.
module tb_exec_issue_arbiter;
  import sched_pkg::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        id;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        cout;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        exp_last = 1'b1;
  exp_t        sb[$];

  exec_issue_arbiter_if bus();

  exec_issue_arbiter #(.LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: {valid, cin, instr} delayed LAT cycles
  logic [33:0] dpq [LAT];
  logic [8:0]  dp_sum;
  always @(posedge clk) begin
    dpq[0] <= {bus.dp_valid, bus.dp_cin, bus.dp_instr};
    for (int i = 1; i < LAT; i++) dpq[i] <= dpq[i-1];
  end
  always_comb begin
    dp_sum = {1'b0, dpq[LAT-1][15:8]} + {1'b0, dpq[LAT-1][7:0]} + {8'b0, dpq[LAT-1][32]};
    if (dpq[LAT-1][31]) begin
      bus.dp_result = dp_sum[7:0];
      bus.dp_cout   = dp_sum[8];
    end else begin
      bus.dp_result = dpq[LAT-1][15:8] & dpq[LAT-1][7:0];
      bus.dp_cout   = 1'b1;
    end
  end

  function automatic exp_t expect_of(input logic id, input logic [31:0] ins, input int unsigned due);
    exp_t e;
    logic [8:0] s;
    e.id   = id;
    e.addr = ins[23:16];
    e.due  = due;
    if (ins[31]) begin
      s      = {1'b0, ins[15:8]} + {1'b0, ins[7:0]} + {8'b0, ins[30]};
      e.data = s[7:0];
      e.cout = s[8];
    end else begin
      e.data = ins[15:8] & ins[7:0];
      e.cout = 1'b0;
    end
    return e;
  endfunction

  // Response monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rsp_valid !== 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got valid=%b id=%0d addr=%h data=%h at cycle %0d, required no response",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_addr, bus.rsp_data, cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_addr, bus.rsp_data, bus.rsp_cout} !== {e.id, e.addr, e.data, e.cout}
            || cyc != e.due) begin
          fails++;
          $display("FAIL rsp_check: got id=%0d addr=%h data=%h cout=%b cycle=%0d, required id=%0d addr=%h data=%h cout=%b cycle=%0d",
                   bus.rsp_id, bus.rsp_addr, bus.rsp_data, bus.rsp_cout, cyc,
                   e.id, e.addr, e.data, e.cout, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [55:0] all_outs();
    return {bus.req0_ready, bus.req1_ready, bus.dp_valid, bus.dp_instr, bus.rsp_valid,
            bus.rsp_id, bus.rsp_addr, bus.rsp_data, bus.rsp_cout, bus.halted, bus.busy};
  endfunction

  // Present one instruction on a port alone and expect it to issue this cycle
  task automatic issue_one(input logic port, input logic [31:0] ins);
    logic exp_cin;
    exp_cin = ins[31] & ins[30];
    if (port) begin bus.req1_valid = 1'b1; bus.req1_instr = ins; end
    else      begin bus.req0_valid = 1'b1; bus.req0_instr = ins; end
    sample();
    tests++;
    if ({bus.req1_ready, bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.dp_cin}
        !== {port, ~port, 1'b1, ins, exp_cin}) begin
      fails++;
      $display("FAIL issue_p%0d: got rdy1=%b rdy0=%b dp_valid=%b dp_instr=%h dp_cin=%b, required rdy1=%b rdy0=%b dp_valid=1 dp_instr=%h dp_cin=%b",
               port, bus.req1_ready, bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.dp_cin,
               port, ~port, ins, exp_cin);
    end
    sb.push_back(expect_of(port, ins, cyc + LAT));
    exp_last = port;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_instr = 32'h8005_0304;
    bus.req1_valid = 1'b1; bus.req1_instr = 32'hC020_FF01;
    repeat (2) tick();
    sample();
    tests++;
    if (all_outs() !== 56'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    exp_last = 1'b1;
    sample();
    tests++;
    if (all_outs() !== 56'h0) begin
      fails++;
      $display("FAIL idle_outputs: got %h, required 0", all_outs());
    end
    tick();
  endtask

  task automatic test_single();
    issue_one(1'b0, 32'h8005_0304);
    sample();
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early: got rsp_valid=%b one cycle after issue, required 0", bus.rsp_valid);
    end
    tick();
    sample();
    tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_addr, bus.rsp_data, bus.rsp_cout} !== {1'b1, 1'b0, 8'h05, 8'h07, 1'b0}) begin
      fails++;
      $display("FAIL single_rsp: got v=%b id=%b addr=%h data=%h cout=%b, required v=1 id=0 addr=05 data=07 cout=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_addr, bus.rsp_data, bus.rsp_cout);
    end
    wait_drain();
  endtask

  task automatic test_add_and();
    issue_one(1'b1, 32'hC020_FF01);
    issue_one(1'b1, 32'h0010_F00F);
    wait_drain();
  endtask

  task automatic test_arbitration();
    logic        w;
    logic [31:0] a0, a1, wi;
    a0 = 32'h8001_0102;
    a1 = 32'h0002_3C0F;
    bus.req0_valid = 1'b1; bus.req0_instr = a0;
    bus.req1_valid = 1'b1; bus.req1_instr = a1;
    for (int k = 0; k < 4; k++) begin
      sample();
`ifdef ISSUE_RR_EN
      w = ~exp_last;
`else
      w = 1'b0;
`endif
      wi = w ? a1 : a0;
      tests++;
      if ({bus.req1_ready, bus.req0_ready, bus.dp_valid, bus.dp_instr} !== {w, ~w, 1'b1, wi}) begin
        fails++;
        $display("FAIL arb_grant%0d: got rdy1=%b rdy0=%b dp_valid=%b dp_instr=%h, required rdy1=%b rdy0=%b dp_valid=1 dp_instr=%h",
                 k, bus.req1_ready, bus.req0_ready, bus.dp_valid, bus.dp_instr, w, ~w, wi);
      end
      sb.push_back(expect_of(w, wi, cyc + LAT));
      exp_last = w;
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    sample();
    tests++;
    if ({bus.req1_ready, bus.req0_ready, bus.dp_valid} !== 3'b000) begin
      fails++;
      $display("FAIL arb_idle: got rdy1=%b rdy0=%b dp_valid=%b, required 000",
               bus.req1_ready, bus.req0_ready, bus.dp_valid);
    end
    tick();
    wait_drain();
  endtask

  task automatic test_halt();
    int unsigned last_ret;
    issue_one(1'b0, 32'h8030_0102);
    issue_one(1'b0, 32'h8030_1020);
    issue_one(1'b0, 32'h0030_FF3C);
    bus.halt_req = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_instr = 32'h80AA_0101;
    sample();
    last_ret = cyc + LAT - 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin tick(); sample(); end
      tests++;
      if ({bus.req0_ready, bus.dp_valid, bus.busy, bus.halted}
          !== {1'b0, 1'b0, cyc <= last_ret, cyc > last_ret}) begin
        fails++;
        $display("FAIL halt_seq%0d: got rdy0=%b dp_valid=%b busy=%b halted=%b, required rdy0=0 dp_valid=0 busy=%b halted=%b",
                 i, bus.req0_ready, bus.dp_valid, bus.busy, bus.halted, cyc <= last_ret, cyc > last_ret);
      end
    end
    tick();
    bus.halt_req = 1'b0;
    sample();
    tests++;
    if ({bus.req0_ready, bus.halted} !== 2'b01) begin
      fails++;
      $display("FAIL halt_release: got rdy0=%b halted=%b, required rdy0=0 halted=1", bus.req0_ready, bus.halted);
    end
    tick();
    sample();
    tests++;
    if ({bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.halted} !== {1'b1, 1'b1, 32'h80AA_0101, 1'b0}) begin
      fails++;
      $display("FAIL halt_resume: got rdy0=%b dp_valid=%b dp_instr=%h halted=%b, required rdy0=1 dp_valid=1 dp_instr=80aa0101 halted=0",
               bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.halted);
    end
    sb.push_back(expect_of(1'b0, 32'h80AA_0101, cyc + LAT));
    exp_last = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    bus.req0_valid = 1'b1;
    bus.req0_instr = 32'h8040_0101;
    tick();
    bus.req0_instr = 32'h8041_0202;
    tick();
    reset = 1'b1;
    sample();
    tests++;
    if ({bus.rsp_valid, bus.req0_ready, bus.dp_valid} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_during: got rsp_valid=%b rdy0=%b dp_valid=%b, required 000",
               bus.rsp_valid, bus.req0_ready, bus.dp_valid);
    end
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    exp_last = 1'b1;
    sample();
    tests++;
    if (all_outs() !== 56'h0) begin
      fails++;
      $display("FAIL rst_mid_after: got %h, required 0", all_outs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      tests++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        fails++;
        $display("FAIL rst_mid_drop%0d: got rsp_valid=%b busy=%b, required 00", i, bus.rsp_valid, bus.busy);
      end
    end
    tick();
  endtask

  task automatic test_halt_pulse();
    issue_one(1'b0, 32'h8050_1111);
    bus.halt_req = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_instr = 32'h8051_2222;
    sample();
    tests++;
    if ({bus.req0_ready, bus.dp_valid, bus.halted} !== 3'b000) begin
      fails++;
      $display("FAIL pulse_block: got rdy0=%b dp_valid=%b halted=%b, required 000",
               bus.req0_ready, bus.dp_valid, bus.halted);
    end
    tick();
    bus.halt_req = 1'b0;
    sample();
    tests++;
    if ({bus.req0_ready, bus.dp_valid, bus.halted} !== 3'b000) begin
      fails++;
      $display("FAIL pulse_drain: got rdy0=%b dp_valid=%b halted=%b, required 000",
               bus.req0_ready, bus.dp_valid, bus.halted);
    end
    tick();
    sample();
    tests++;
    if ({bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.halted} !== {1'b1, 1'b1, 32'h8051_2222, 1'b0}) begin
      fails++;
      $display("FAIL pulse_run: got rdy0=%b dp_valid=%b dp_instr=%h halted=%b, required rdy0=1 dp_valid=1 dp_instr=80512222 halted=0",
               bus.req0_ready, bus.dp_valid, bus.dp_instr, bus.halted);
    end
    sb.push_back(expect_of(1'b0, 32'h8051_2222, cyc + LAT));
    exp_last = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_instr = '0;
    bus.req1_valid = 1'b0; bus.req1_instr = '0;
    bus.halt_req   = 1'b0;
    test_reset();
    test_single();
    test_add_and();
    test_arbitration();
    test_halt();
    test_reset_midflight();
    test_halt_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_issue_arbiter.md
# exec_issue_arbiter

Issue controller for the 8-bit add/AND execute datapath. Two instruction requesters share the datapath through valid/ready handshakes. The block grants one instruction per cycle and drives it into the datapath. It tracks in-flight instructions in a tag pipeline whose depth matches the datapath latency, and returns each result to its owner. It also provides a drain/halt sequence so software can quiesce the datapath before memory inspection.

## Interface
- LAT, 2, datapath latency in cycles from dp_valid to dp_result (EX + WB register), 1..4
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an instruction
- req0_instr  in  32  requester 0 instruction: [31] op (1=add, 0=AND), [30] cin, [23:16] dest addr, [15:8] x, [7:0] y
- req0_ready  out  1  requester 0 instruction accepted this cycle when valid
- req1_valid, req1_instr, req1_ready  same widths/meaning for requester 1
- dp_valid  out  1  instruction presented to datapath this cycle
- dp_instr  out  32  instruction to datapath
- dp_cin  out  1  carry-in: instr[30] when instr[31]=1, else 0
- dp_result  in  8  datapath result, valid LAT cycles after dp_valid
- dp_cout  in  1  datapath carry-out, same timing
- rsp_valid  out  1  response strobe, no backpressure
- rsp_id  out  1  requester that owns the response
- rsp_addr  out  8  destination address of the retired instruction
- rsp_data  out  8  result byte
- rsp_cout  out  1  carry-out, forced 0 for AND ops
- halt_req  in  1  level request to drain and stop issuing
- halted  out  1  datapath empty and issue stopped
- busy  out  1  at least one instruction in flight

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- RUN:
  - Grant is allowed only when halt_req=0.
  - The grant goes to one valid requester.
  - reqN_ready=1 only for the granted port. It is combinational from the valids, state and halt_req.
  - Issue occurs when valid&ready on the granted port.
- Arbitration:
  - last_grant register, reset value 1, so port 0 wins first.
  - When both ports are valid, the port other than last_grant wins. A single valid port always wins.
  - last_grant updates only on an issue.
- Issue cycle:
  - dp_valid=1 and dp_instr=granted instr.
  - The tag pipeline stage 0 captures {valid=1, id, addr=instr[23:16], op=instr[31]}.
  - Tags shift one stage per cycle unconditionally.
- Retire:
  - When the last tag stage is valid, rsp_valid=1 with id/addr from the tag, rsp_data=dp_result, and rsp_cout=dp_cout&op.
  - Responses are combinational from the last tag stage and the dp inputs.
- Transitions:
  - RUN→DRAIN when halt_req=1.
  - DRAIN→HALTED when no tag is valid and halt_req=1.
  - DRAIN→RUN when no tag is valid and halt_req=0.
  - HALTED→RUN when halt_req=0.
- No issue occurs in DRAIN or HALTED. Instructions already in flight always retire.
- halted=1 only in HALTED. busy = OR of tag valids.
- Writes to the same address retire in issue order. There is no reordering and no hazard stall, because operands are immediates.

## Timing
- Issue at cycle t produces rsp_valid at cycle t+LAT. Throughput is one instruction per cycle.
- halt_req rising at cycle t blocks issue in cycle t itself.
- halted rises at t+1 if the pipeline is empty, otherwise in the cycle after the last retire.
- Reset values:
  - dp_valid=0, dp_instr=0, rsp_valid=0, rsp_id=0, rsp_addr=0, rsp_data=0, rsp_cout=0.
  - halted=0, busy=0, reqN_ready=0 (ready is also 0 during reset).
- Reset mid-operation clears all tags. In-flight responses are dropped, not delivered.
- When a requester drops valid before acceptance, no issue occurs and last_grant is unchanged.
- A requester may hold valid across a lost arbitration. Its instr must stay stable until accepted.

## Configuration
- ISSUE_RR_EN defined: round-robin arbitration as above.
- ISSUE_RR_EN undefined: fixed priority, port 0 always wins. The last_grant register is removed, and port 1 is served only when req0_valid=0.

## Structure
- Shared package sched_pkg holds:
  - state enum (RUN/DRAIN/HALTED)
  - default LAT
  - instruction field positions: OP_BIT=31, CIN_BIT=30, ADDR_MSB/LSB=23/16, X 15:8, Y 7:0
  - tag struct {valid, id, addr, op}
- One sub-module, rr_arbiter2: two requests plus last_grant in, one-hot grant out. It contains the ISSUE_RR_EN selection.

## Test plan
- req0 32'h8005_0304 alone → dp_valid at t. At t+2: rsp_valid, id 0, addr 0x05, data 0x07, cout 0.
- req1 32'hC020_FF01 (add, cin=1) → dp_cin=1. At t+2: data 0x01, cout 1, id 1. Then AND 32'h8010_F00F with bit31 cleared (0x0010_F00F) → data 0x00, cout 0 even if the model drives dp_cout=1.
- Both valid for 4 cycles → grants 0,1,0,1 with ISSUE_RR_EN. Without it: 0,0,0,0 and req1_ready stays 0.
- Issue 3 back-to-back, then halt_req=1 → no further ready; busy until the last rsp; halted asserted the cycle after the last retire. halt_req=0 → RUN next cycle and issue resumes.
- reset asserted with 2 in flight → rsp_valid never pulses for them. busy=0 and all outputs at reset values the cycle after.
- halt_req pulses 1 for one cycle while the pipeline holds 1 op → DRAIN, then RUN (not HALTED) after the retire; halted stays 0.
